// File: rtl/lsu_bus_pkg.sv
// Shared types and constants for the LSU bus controller: FSM states, RISC-V
// load/store funct3 codes and the access legality check.
package lsu_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [3:0] BE_WORD = 4'hF;

   // True when funct3 is legal for the direction and the address is naturally aligned.
   function automatic logic access_ok(input logic we, input logic [2:0] fct3,
                                      input logic [1:0] addr_lo);
      logic ok;
      case (fct3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~addr_lo[0];
         F3_W:    ok = (addr_lo == 2'b00);
         F3_BU:   ok = ~we;
         F3_HU:   ok = ~we & ~addr_lo[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store enables/replicated data toward the
// bus and lane selection plus sign/zero extension of load data.
module lsu_lane_align
   import lsu_bus_pkg::*;
(
   input  logic [2:0]  fct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection of the returned bus word.
   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Enables, replicated store data and extended load data per access size.
   always_comb begin
      be         = 4'h0;
      wdata_lane = 32'h0;
      rdata_ext  = 32'h0;
      case (fct3)
         F3_B: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = {{24{byte_sel[7]}}, byte_sel};
         end
         F3_BU: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = {24'h0, byte_sel};
         end
         F3_H: begin
            be         = addr_lo[1] ? 4'hC : 4'h3;
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = {{16{half_sel[15]}}, half_sel};
         end
         F3_HU: begin
            be         = addr_lo[1] ? 4'hC : 4'h3;
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = {16'h0, half_sel};
         end
         F3_W: begin
            be         = BE_WORD;
            wdata_lane = wdata;
            rdata_ext  = rdata;
         end
         default: begin
            be         = 4'h0;
            wdata_lane = 32'h0;
            rdata_ext  = 32'h0;
         end
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Single-outstanding load/store sequencer between the core memory stage and a
// req/ack data bus. Optional hung-transfer abort under LSU_BUS_CTRL_TIMEOUT_EN.
module lsu_bus_ctrl
   import lsu_bus_pkg::*;
`ifdef LSU_BUS_CTRL_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
)
`endif
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_fct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   state_t      state_r, state_nxt;
   logic        we_r;
   logic [2:0]  fct3_r;
   logic [1:0]  addr_lo_r;
   logic        cap_en;
   logic        tmo_hit;

   logic        bus_req_nxt, bus_we_nxt, rsp_valid_nxt, rsp_err_nxt;
   logic [31:0] bus_addr_nxt, bus_wdata_nxt, rsp_rdata_nxt;
   logic [3:0]  bus_be_nxt;

   logic [2:0]  al_fct3;
   logic [1:0]  al_addr;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_rdata;

   // The aligner sees the live request while idle and the captured one while busy.
   assign al_fct3 = (state_r == ST_IDLE) ? req_fct3 : fct3_r;
   assign al_addr = (state_r == ST_IDLE) ? req_addr[1:0] : addr_lo_r;

   lsu_lane_align u_align (
      .fct3       (al_fct3),
      .addr_lo    (al_addr),
      .wdata      (req_wdata),
      .rdata      (bus_rdata),
      .be         (al_be),
      .wdata_lane (al_wdata),
      .rdata_ext  (al_rdata)
   );

   assign req_ready = (state_r == ST_IDLE);
   assign busy      = (state_r != ST_IDLE);

`ifdef LSU_BUS_CTRL_TIMEOUT_EN
   logic [7:0] tmo_cnt_r;

   // Counts BUSY cycles without ack; cleared whenever BUSY is entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_r <= 8'd0;
      end else if (state_r != ST_BUSY && state_nxt == ST_BUSY) begin
         tmo_cnt_r <= 8'd0;
      end else if (state_r == ST_BUSY && !bus_ack) begin
         tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   // Hit on the cycle whose increment would reach the limit, so the abort edge
   // coincides with the last counted BUSY cycle.
   assign tmo_hit = (tmo_cnt_r == 8'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // Next-state and next registered-output decode.
   always_comb begin
      state_nxt     = state_r;
      cap_en        = 1'b0;
      bus_req_nxt   = bus_req;
      bus_we_nxt    = bus_we;
      bus_addr_nxt  = bus_addr;
      bus_be_nxt    = bus_be;
      bus_wdata_nxt = bus_wdata;
      rsp_valid_nxt = 1'b0;
      rsp_err_nxt   = 1'b0;
      rsp_rdata_nxt = 32'h0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               cap_en = 1'b1;
               if (access_ok(req_we, req_fct3, req_addr[1:0])) begin
                  state_nxt     = ST_BUSY;
                  bus_req_nxt   = 1'b1;
                  bus_we_nxt    = req_we;
                  bus_addr_nxt  = {req_addr[31:2], 2'b00};
                  bus_be_nxt    = al_be;
                  bus_wdata_nxt = al_wdata;
               end else begin
                  state_nxt     = ST_ERR;
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = 1'b1;
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (bus_ack) begin
               state_nxt     = ST_RESP;
               bus_req_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = we_r ? 32'h0 : al_rdata;
            end else if (tmo_hit) begin
               state_nxt     = ST_ERR;
               bus_req_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
            end else begin
               state_nxt = ST_BUSY;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         ST_ERR:  state_nxt = ST_IDLE;
         default: begin
            state_nxt   = ST_IDLE;
            bus_req_nxt = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nxt;
   end

   // Registered bus/response outputs and the captured request fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_be    <= 4'h0;
         bus_wdata <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'h0;
         we_r      <= 1'b0;
         fct3_r    <= 3'd0;
         addr_lo_r <= 2'd0;
      end else begin
         bus_req   <= bus_req_nxt;
         bus_we    <= bus_we_nxt;
         bus_addr  <= bus_addr_nxt;
         bus_be    <= bus_be_nxt;
         bus_wdata <= bus_wdata_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_err   <= rsp_err_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         if (cap_en) begin
            we_r      <= req_we;
            fct3_r    <= req_fct3;
            addr_lo_r <= req_addr[1:0];
         end else begin
            we_r      <= we_r;
            fct3_r    <= fct3_r;
            addr_lo_r <= addr_lo_r;
         end
      end
   end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized transactions against a reference model.
module tb_lsu_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [2:0]  req_fct3;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic        bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

`ifdef LSU_BUS_CTRL_TIMEOUT_EN
   lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
`else
   lsu_bus_ctrl dut (
`endif
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_fct3(req_fct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          dly;
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model: derived from access size and byte offset with plain arithmetic.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        output logic err, output logic [3:0] be,
                        output logic [31:0] wd, output logic [31:0] rd);
      int unsigned off, size;
      bit legal;
      logic [31:0] mask, val;
      off   = addr % 4;
      legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size  = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
      err   = !legal || (off % size != 0);
      if (size == 1) begin
         be = 4'(1 << off); mask = 32'h0000_00FF; wd = (wdata & mask) * 32'h0101_0101;
      end else if (size == 2) begin
         be = (off >= 2) ? 4'd12 : 4'd3; mask = 32'h0000_FFFF; wd = (wdata & mask) * 32'h0001_0001;
      end else begin
         be = 4'd15; mask = 32'hFFFF_FFFF; wd = wdata;
      end
      val = (rdata >> (8 * off)) & mask;
      if (f3 < 3'd4 && size < 4 && ((val & ~(mask >> 1)) != 32'h0)) val = val | ~mask;
      rd = (we || err) ? 32'h0 : val;
   endtask

   // One complete transaction from an idle controller, checked cycle by cycle.
   task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int dly, input logic [31:0] rdata,
                          input logic e_err, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input logic [31:0] e_rd);
      chk("ready_idle", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; req_we = we; req_fct3 = f3; req_addr = addr; req_wdata = wdata;
      tick();
      req_valid = 1'b0;
      if (e_err) begin
         chk("err_valid", {31'h0, rsp_valid}, 32'h1);
         chk("err_flag", {31'h0, rsp_err}, 32'h1);
         chk("err_rdata", rsp_rdata, 32'h0);
         chk("err_no_bus", {31'h0, bus_req}, 32'h0);
         tick();
         chk("err_done", {30'h0, rsp_valid, busy}, 32'h0);
      end else begin
         for (int i = 0; i <= dly; i++) begin
            chk("busy_req", {31'h0, bus_req}, 32'h1);
            chk("busy_we", {31'h0, bus_we}, {31'h0, we});
            chk("busy_addr", bus_addr, addr & 32'hFFFF_FFFC);
            chk("busy_be", {28'h0, bus_be}, {28'h0, e_be});
            if (we) chk("busy_wdata", bus_wdata, e_wd);
            chk("busy_nrsp", {31'h0, rsp_valid}, 32'h0);
            chk("busy_ready", {31'h0, req_ready}, 32'h0);
            bus_ack   = (i == dly);
            bus_rdata = (i == dly) ? rdata : $urandom;
            tick();
         end
         bus_ack = 1'b0;
         chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
         chk("rsp_err", {31'h0, rsp_err}, 32'h0);
         chk("rsp_rdata", rsp_rdata, e_rd);
         chk("rsp_req_low", {31'h0, bus_req}, 32'h0);
         tick();
         chk("rsp_pulse", {31'h0, rsp_valid}, 32'h0);
      end
   endtask

   initial begin
      logic        m_err;
      logic [3:0]  m_be;
      logic [31:0] m_wd, m_rd;
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_wd, r_rd;
      int          r_dly;

      vecs[0]  = '{1'b1, 3'd0, 32'h1003, 32'h0000_00A5, 0, 32'h0,         1'b0, 4'h8, 32'hA5A5_A5A5, 32'h0};
      vecs[1]  = '{1'b0, 3'd1, 32'h2002, 32'h0,         3, 32'h8001_1234, 1'b0, 4'hC, 32'h0,         32'hFFFF_8001};
      vecs[2]  = '{1'b0, 3'd5, 32'h2002, 32'h0,         3, 32'h8001_1234, 1'b0, 4'hC, 32'h0,         32'h0000_8001};
      vecs[3]  = '{1'b0, 3'd2, 32'h3001, 32'h0,         0, 32'h0,         1'b1, 4'h0, 32'h0,         32'h0};
      vecs[4]  = '{1'b0, 3'd3, 32'h3000, 32'h0,         0, 32'h0,         1'b1, 4'h0, 32'h0,         32'h0};
      vecs[5]  = '{1'b1, 3'd4, 32'h3000, 32'h0,         0, 32'h0,         1'b1, 4'h0, 32'h0,         32'h0};
      vecs[6]  = '{1'b1, 3'd1, 32'h0012, 32'hFFFF_BEEF, 1, 32'h0,         1'b0, 4'hC, 32'hBEEF_BEEF, 32'h0};
      vecs[7]  = '{1'b1, 3'd2, 32'h0020, 32'h1234_5678, 2, 32'h0,         1'b0, 4'hF, 32'h1234_5678, 32'h0};
      vecs[8]  = '{1'b0, 3'd0, 32'h0005, 32'h0,         1, 32'h0000_8000, 1'b0, 4'h2, 32'h0,         32'hFFFF_FF80};
      vecs[9]  = '{1'b0, 3'd4, 32'h0007, 32'h0,         0, 32'hAB00_0000, 1'b0, 4'h8, 32'h0,         32'h0000_00AB};
      vecs[10] = '{1'b1, 3'd1, 32'h0001, 32'h1111,      0, 32'h0,         1'b1, 4'h0, 32'h0,         32'h0};
      vecs[11] = '{1'b0, 3'd2, 32'h0008, 32'h0,         1, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEEF};
      vecs[12] = '{1'b1, 3'd5, 32'h0000, 32'h0,         0, 32'h0,         1'b1, 4'h0, 32'h0,         32'h0};
      vecs[13] = '{1'b0, 3'd7, 32'h0000, 32'h0,         0, 32'h0,         1'b1, 4'h0, 32'h0,         32'h0};

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_fct3 = 3'd0;
      req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_ctrl", {26'h0, bus_req, bus_we, rsp_valid, rsp_err, busy, req_ready}, 32'h1);
      chk("reset_addr", bus_addr, 32'h0);
      chk("reset_be", {28'h0, bus_be}, 32'h0);
      chk("reset_wdata", bus_wdata, 32'h0);
      chk("reset_rdata", rsp_rdata, 32'h0);

      // Ack while idle must be ignored.
      bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
      tick();
      bus_ack = 1'b0;
      chk("stray_ack", {29'h0, rsp_valid, busy, bus_req}, 32'h0);

      for (int v = 0; v < 14; v++)
         run_txn(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata, vecs[v].dly,
                 vecs[v].rdata, vecs[v].err, vecs[v].be, vecs[v].wd, vecs[v].rd);

      // Reset during the second BUSY cycle of an SW, then a late ack.
      req_valid = 1'b1; req_we = 1'b1; req_fct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
      tick();
      req_valid = 1'b0;
      tick();
      chk("rst_busy_pre", {31'h0, bus_req}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      chk("rst_busy_ctrl", {26'h0, bus_req, bus_we, rsp_valid, rsp_err, busy, req_ready}, 32'h1);
      chk("rst_busy_addr", bus_addr, 32'h0);
      chk("rst_busy_be", {28'h0, bus_be}, 32'h0);
      chk("rst_busy_wdata", bus_wdata, 32'h0);
      tick();
      bus_ack = 1'b0;
      chk("late_ack", {30'h0, rsp_valid, busy}, 32'h0);
      tick();
      chk("late_ack2", {31'h0, rsp_valid}, 32'h0);
      run_txn(1'b0, 3'd0, 32'h0, 32'h0, 0, 32'h0000_007F, 1'b0, 4'h1, 32'h0, 32'h0000_007F);

      // Back-to-back stores with req_valid held high.
      req_valid = 1'b1; req_we = 1'b1; req_fct3 = 3'd0; req_addr = 32'h100; req_wdata = 32'h11;
      tick();
      req_addr = 32'h202; req_wdata = 32'h22;
      chk("b2b_first_be", {28'h0, bus_be}, 32'h1);
      chk("b2b_ready_busy", {31'h0, req_ready}, 32'h0);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      chk("b2b_rsp1", {31'h0, rsp_valid}, 32'h1);
      chk("b2b_ready_resp", {31'h0, req_ready}, 32'h0);
      tick();
      chk("b2b_idle_gap", {30'h0, bus_req, req_ready}, 32'h1);
      tick();
      req_valid = 1'b0;
      chk("b2b_second_req", {31'h0, bus_req}, 32'h1);
      chk("b2b_second_be", {28'h0, bus_be}, 32'h4);
      chk("b2b_second_wd", bus_wdata, 32'h2222_2222);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      chk("b2b_rsp2", {31'h0, rsp_valid}, 32'h1);
      tick();

`ifdef LSU_BUS_CTRL_TIMEOUT_EN
      // No ack: four BUSY cycles then abort with an error response.
      req_valid = 1'b1; req_we = 1'b0; req_fct3 = 3'd2; req_addr = 32'h80;
      tick();
      req_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk("tmo_req_high", {31'h0, bus_req}, 32'h1);
         chk("tmo_no_rsp", {31'h0, rsp_valid}, 32'h0);
         tick();
      end
      chk("tmo_req_drop", {31'h0, bus_req}, 32'h0);
      chk("tmo_rsp", {30'h0, rsp_valid, rsp_err}, 32'h3);
      chk("tmo_rdata", rsp_rdata, 32'h0);
      tick();
      run_txn(1'b0, 3'd2, 32'h84, 32'h0, 3, 32'h0BAD_CAFE, 1'b0, 4'hF, 32'h0, 32'h0BAD_CAFE);
`endif

      for (int n = 0; n < 40; n++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_f3   = 3'($urandom_range(0, 7));
         r_addr = $urandom;
         r_wd   = $urandom;
         r_rd   = $urandom;
         r_dly  = $urandom_range(0, 3);
         model(r_we, r_f3, r_addr, r_wd, r_rd, m_err, m_be, m_wd, m_rd);
         run_txn(r_we, r_f3, r_addr, r_wd, r_dly, r_rd, m_err, m_be, m_wd, m_rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
